// File: rtl/branch_predict_bht_pkg.sv
// rtl/branch_predict_bht_pkg.sv - shared defaults and helpers for the branch history table
//
// Purpose: default parameter values and the sequential-fetch PC increment used
//          by the predictor and anything else in the fetch/decode slice.
// Ports:   none (package).

package branch_predict_bht_pkg;

    typedef logic [31:0] addr_t;

    localparam int DEF_ENTRIES = 64;
    localparam int DEF_TAG_W   = 8;
    localparam int DEF_CNT_W   = 2;

    localparam addr_t PC_INC = 32'd4;

    // Fall-through fetch address; wraps modulo 2^32.
    function automatic addr_t next_seq_pc(input addr_t pc);
        return pc + PC_INC;
    endfunction

endpackage

// File: rtl/branch_predict_bht_if.sv
// rtl/branch_predict_bht_if.sv - lookup and training bus between fetch/ID and the BHT
//
// Purpose: groups the fetch-side lookup and the ID-side training signals.
// Ports (signals):
//   pc_lookup      fetch PC to predict              (master -> slave)
//   pred_hit       valid entry with matching tag    (slave -> master)
//   pred_taken     predict taken                    (slave -> master)
//   pred_target    predicted next PC                (slave -> master)
//   upd_valid      train this cycle                 (master -> slave)
//   upd_pc         PC of the resolved branch        (master -> slave)
//   upd_taken      actual outcome                   (master -> slave)
//   upd_target     actual taken target              (master -> slave)
//   upd_mispredict fetch prediction was wrong       (master -> slave)

interface branch_predict_bht_if;
    import branch_predict_bht_pkg::*;

    addr_t pc_lookup;
    logic  pred_hit;
    logic  pred_taken;
    addr_t pred_target;

    logic  upd_valid;
    addr_t upd_pc;
    logic  upd_taken;
    addr_t upd_target;
    logic  upd_mispredict;

    modport master (
        output pc_lookup,
        input  pred_hit,
        input  pred_taken,
        input  pred_target,
        output upd_valid,
        output upd_pc,
        output upd_taken,
        output upd_target,
        output upd_mispredict
    );

    modport slave (
        input  pc_lookup,
        output pred_hit,
        output pred_taken,
        output pred_target,
        input  upd_valid,
        input  upd_pc,
        input  upd_taken,
        input  upd_target,
        input  upd_mispredict
    );

endinterface

// File: rtl/branch_predict_bht_sat_counter.sv
// rtl/branch_predict_bht_sat_counter.sv - CNT_W-bit up/down counter saturating at both ends
//
// Purpose: next-value logic for a direction counter.
// Ports:
//   cur  in  CNT_W  current counter value
//   inc  in  1      step up (held at all-ones)
//   dec  in  1      step down (held at zero)
//   nxt  out CNT_W  next counter value

module sat_counter #(
    parameter int CNT_W = 2
) (
    input  logic [CNT_W-1:0] cur,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] nxt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_MIN = '0;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Simultaneous inc and dec cancel out and leave the value unchanged.
    always_comb begin
        nxt = cur;
        if (inc && !dec && (cur != CNT_MAX)) begin
            nxt = cur + CNT_ONE;
        end else if (dec && !inc && (cur != CNT_MIN)) begin
            nxt = cur - CNT_ONE;
        end
    end

endmodule

// File: rtl/branch_predict_bht.sv
// rtl/branch_predict_bht.sv - tagged branch history table with target buffer
//
// Purpose: per-entry valid bit, partial PC tag, saturating direction counter
//          and 32-bit target. Combinational lookup for fetch, one training
//          write per cycle from ID, plus resolved-branch / mispredict counters.
// Ports:
//   clock             in   rising-edge clock
//   reset_0           in   asynchronous active-low reset
//   bus               slave modport of branch_predict_bht_if (lookup + training)
//   stat_branches     out  32  count of training cycles (wraps)
//   stat_mispredicts  out  32  count of training cycles flagged mispredict (wraps)

module branch_predict_bht
    import branch_predict_bht_pkg::*;
#(
    parameter int ENTRIES = DEF_ENTRIES,
    parameter int TAG_W   = DEF_TAG_W,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic                 clock,
    input  logic                 reset_0,
    branch_predict_bht_if.slave  bus,
    output logic [31:0]          stat_branches,
    output logic [31:0]          stat_mispredicts
);

    localparam int IDX_W = $clog2(ENTRIES);

    // Allocation starts weakly taken; reset leaves entries weakly not taken.
    localparam logic [CNT_W-1:0] CNT_WEAK_T  = CNT_W'(1) << (CNT_W - 1);
    localparam logic [CNT_W-1:0] CNT_WEAK_NT = CNT_WEAK_T - CNT_W'(1);

    // Plain register arrays so the asynchronous reset can clear every entry.
    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [CNT_W-1:0] cnt_q    [ENTRIES];
    addr_t            target_q [ENTRIES];

    // ---------------------------------------------------------------
    // Lookup: purely combinational, reads pre-update contents.
    // ---------------------------------------------------------------
    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;
    logic             lk_taken;

    assign lk_idx   = bus.pc_lookup[IDX_W+1:2];
    assign lk_tag   = bus.pc_lookup[IDX_W+2 +: TAG_W];
    assign lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign lk_taken = lk_hit && cnt_q[lk_idx][CNT_W-1];

    assign bus.pred_hit    = lk_hit;
    assign bus.pred_taken  = lk_taken;
    assign bus.pred_target = lk_taken ? target_q[lk_idx] : next_seq_pc(bus.pc_lookup);

    // ---------------------------------------------------------------
    // Training path
    // ---------------------------------------------------------------
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;
    logic [CNT_W-1:0] up_cnt_nxt;

    assign up_idx = bus.upd_pc[IDX_W+1:2];
    assign up_tag = bus.upd_pc[IDX_W+2 +: TAG_W];
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_sat_counter (
        .cur (cnt_q[up_idx]),
        .inc (bus.upd_taken),
        .dec (!bus.upd_taken),
        .nxt (up_cnt_nxt)
    );

    always_ff @(posedge clock or negedge reset_0) begin
        if (!reset_0) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                cnt_q[i]    <= CNT_WEAK_NT;
                target_q[i] <= '0;
            end
        end else if (bus.upd_valid) begin
            if (up_hit) begin
                cnt_q[up_idx] <= up_cnt_nxt;
                if (bus.upd_taken) begin
                    target_q[up_idx] <= bus.upd_target;
                end
            end else if (bus.upd_taken) begin
                // A taken miss evicts whatever aliases at this index.
                valid_q[up_idx]  <= 1'b1;
                tag_q[up_idx]    <= up_tag;
                cnt_q[up_idx]    <= CNT_WEAK_T;
                target_q[up_idx] <= bus.upd_target;
            end
            // A not-taken miss is not worth an entry: it would predict fall-through anyway.
        end
    end

    // ---------------------------------------------------------------
    // Event counters
    // ---------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_0) begin
        if (!reset_0) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else if (bus.upd_valid) begin
            stat_branches <= stat_branches + 32'd1;
            if (bus.upd_mispredict) begin
                stat_mispredicts <= stat_mispredicts + 32'd1;
            end
        end
    end

    // Low PC bits and tag-external high bits do not participate in indexing.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bus.pc_lookup, bus.upd_pc};

endmodule

// File: tb/tb_branch_predict_bht.sv
// tb/tb_branch_predict_bht.sv - directed self-checking bench for branch_predict_bht

module tb_branch_predict_bht;

    logic        clock;
    logic        reset_0;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    int n_cmp;
    int n_err;

    branch_predict_bht_if bus ();

    branch_predict_bht #(
        .ENTRIES (16),
        .TAG_W   (8),
        .CNT_W   (2)
    ) dut (
        .clock            (clock),
        .reset_0          (reset_0),
        .bus              (bus),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One training cycle: present inputs, let the edge sample them, then idle.
    task automatic upd(input logic [31:0] pc, input logic taken,
                       input logic [31:0] target, input logic mis);
        bus.upd_valid      = 1'b1;
        bus.upd_pc         = pc;
        bus.upd_taken      = taken;
        bus.upd_target     = target;
        bus.upd_mispredict = mis;
        @(posedge clock);
        #1;
        bus.upd_valid      = 1'b0;
        bus.upd_mispredict = 1'b0;
    endtask

    task automatic look(input logic [31:0] pc);
        bus.pc_lookup = pc;
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset_0            = 1'b0;
        bus.pc_lookup      = 32'h0;
        bus.upd_valid      = 1'b0;
        bus.upd_pc         = 32'h0;
        bus.upd_taken      = 1'b0;
        bus.upd_target     = 32'h0;
        bus.upd_mispredict = 1'b0;
        #12;
        reset_0 = 1'b1;

        // Reset state
        look(32'h40);
        chk("rst_hit",    {31'b0, bus.pred_hit},   32'h0);
        chk("rst_taken",  {31'b0, bus.pred_taken}, 32'h0);
        chk("rst_target", bus.pred_target,         32'h44);
        chk("rst_br",     stat_branches,           32'h0);
        chk("rst_mis",    stat_mispredicts,        32'h0);
        look(32'hFFFF_FFFC);
        chk("wrap_target", bus.pred_target,        32'h0);

        // Allocation and counter walk at pc 0x40 (idx 0, tag 0x01)
        upd(32'h40, 1'b1, 32'h100, 1'b0);                      // cnt 2
        look(32'h40);
        chk("alloc_hit",    {31'b0, bus.pred_hit},   32'h1);
        chk("alloc_taken",  {31'b0, bus.pred_taken}, 32'h1);
        chk("alloc_target", bus.pred_target,         32'h100);
        upd(32'h40, 1'b1, 32'h100, 1'b0);                      // cnt 3
        upd(32'h40, 1'b1, 32'h100, 1'b0);                      // cnt 3 (sat)
        upd(32'h40, 1'b1, 32'h100, 1'b0);                      // cnt 3 (sat)
        upd(32'h40, 1'b0, 32'h0,   1'b0);                      // cnt 2
        look(32'h40);
        chk("sat3_dec_taken",  {31'b0, bus.pred_taken}, 32'h1);
        chk("sat3_dec_target", bus.pred_target,         32'h100);
        upd(32'h40, 1'b0, 32'h0,   1'b0);                      // cnt 1
        look(32'h40);
        chk("cnt1_hit",    {31'b0, bus.pred_hit},   32'h1);
        chk("cnt1_taken",  {31'b0, bus.pred_taken}, 32'h0);
        chk("cnt1_target", bus.pred_target,         32'h44);
        upd(32'h40, 1'b0, 32'h0,   1'b0);                      // cnt 0
        upd(32'h40, 1'b0, 32'h0,   1'b0);                      // cnt 0 (sat)
        upd(32'h40, 1'b1, 32'h104, 1'b0);                      // cnt 1
        look(32'h40);
        chk("sat0_inc_taken", {31'b0, bus.pred_taken}, 32'h0);

        // Same-cycle lookup and update: pre-update contents, then new
        bus.pc_lookup      = 32'h40;
        bus.upd_valid      = 1'b1;
        bus.upd_pc         = 32'h40;
        bus.upd_taken      = 1'b1;
        bus.upd_target     = 32'h108;
        bus.upd_mispredict = 1'b0;
        #1;
        chk("haz_before_taken", {31'b0, bus.pred_taken}, 32'h0);
        @(posedge clock);
        #1;
        bus.upd_valid = 1'b0;
        chk("haz_after_taken",  {31'b0, bus.pred_taken}, 32'h1);
        chk("haz_after_target", bus.pred_target,         32'h108);

        // Aliasing at idx 0: 0x80 carries tag 0x02
        look(32'h80);
        chk("alias_pre_hit", {31'b0, bus.pred_hit}, 32'h0);
        upd(32'h80, 1'b1, 32'h200, 1'b0);
        look(32'h80);
        chk("alias_new_hit",    {31'b0, bus.pred_hit}, 32'h1);
        chk("alias_new_target", bus.pred_target,       32'h200);
        look(32'h40);
        chk("alias_old_hit",    {31'b0, bus.pred_hit}, 32'h0);
        chk("alias_old_target", bus.pred_target,       32'h44);
        chk("pre_rst_br",  stat_branches,    32'd11);
        chk("pre_rst_mis", stat_mispredicts, 32'd0);

        // Asynchronous reset asserted mid-cycle during a training cycle
        bus.pc_lookup      = 32'h80;
        bus.upd_valid      = 1'b1;
        bus.upd_pc         = 32'h44;
        bus.upd_taken      = 1'b1;
        bus.upd_target     = 32'h300;
        bus.upd_mispredict = 1'b1;
        #2;
        reset_0 = 1'b0;
        #1;
        chk("arst_hit",    {31'b0, bus.pred_hit},   32'h0);
        chk("arst_taken",  {31'b0, bus.pred_taken}, 32'h0);
        chk("arst_target", bus.pred_target,         32'h84);
        chk("arst_br",     stat_branches,           32'h0);
        chk("arst_mis",    stat_mispredicts,        32'h0);
        @(posedge clock);
        #1;
        bus.upd_valid      = 1'b0;
        bus.upd_mispredict = 1'b0;
        reset_0            = 1'b1;
        look(32'h44);
        chk("arst_nowrite_hit", {31'b0, bus.pred_hit}, 32'h0);
        chk("arst_br_held",     stat_branches,         32'h0);

        // Not-taken miss on a fresh table does not allocate; statistics run
        upd(32'h80, 1'b0, 32'h200, 1'b0);
        look(32'h80);
        chk("nt_miss_hit", {31'b0, bus.pred_hit}, 32'h0);
        upd(32'h40, 1'b1, 32'h100, 1'b1);
        upd(32'h40, 1'b1, 32'h100, 1'b0);
        upd(32'h44, 1'b0, 32'h0,   1'b1);
        upd(32'h48, 1'b1, 32'h500, 1'b0);
        look(32'h48);
        chk("idx2_hit",    {31'b0, bus.pred_hit}, 32'h1);
        chk("idx2_target", bus.pred_target,       32'h500);
        upd(32'h40, 1'b0, 32'h0,   1'b0);
        upd(32'h48, 1'b0, 32'h0,   1'b1);
        upd(32'h4C, 1'b1, 32'h600, 1'b0);
        upd(32'h4C, 1'b1, 32'h600, 1'b0);
        upd(32'h4C, 1'b1, 32'h600, 1'b0);
        // Mispredict without a valid training cycle must not count
        bus.upd_mispredict = 1'b1;
        @(posedge clock);
        #1;
        bus.upd_mispredict = 1'b0;
        chk("stat_br",  stat_branches,    32'd10);
        chk("stat_mis", stat_mispredicts, 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/branch_predict_bht.md
# branch_predict_bht

Parametrised branch history table with a tagged target buffer. It replaces the single-entry two-flop predictor beside `stage_id`. Each entry holds a valid bit, a partial PC tag, a CNT_W-bit saturating direction counter and a 32-bit target. The fetch stage queries it combinationally with the current PC; the ID stage trains it once per resolved branch or jump. Two event counters (resolved branches, mispredicts) give performance visibility.

## Interface
- `ENTRIES`, 64, number of entries, power of 2, ≥4; IDX_W = log2(ENTRIES)
- `TAG_W`, 8, stored tag width; IDX_W+2+TAG_W ≤ 32
- `CNT_W`, 2, direction counter width, ≥1
- `clock`  in  1  single clock; all state updates on rising edge
- `reset_0`  in  1  asynchronous, active-low reset
- `pc_lookup`  in  32  fetch PC to predict
- `pred_hit`  out  1  valid entry with matching tag
- `pred_taken`  out  1  predict taken
- `pred_target`  out  32  predicted next PC
- `upd_valid`  in  1  train this cycle
- `upd_pc`  in  32  PC of the resolved branch
- `upd_taken`  in  1  actual outcome
- `upd_target`  in  32  actual taken target (pc_b / pc_j / jr register)
- `upd_mispredict`  in  1  prediction used at fetch was wrong; qualified by upd_valid
- `stat_branches`  out  32  count of upd_valid cycles
- `stat_mispredicts`  out  32  count of upd_valid & upd_mispredict cycles

## Operation
- Index = pc[IDX_W+1:2]. Tag = pc[IDX_W+2 +: TAG_W].
- Lookup is purely combinational on pc_lookup.
  - pred_hit = valid[idx] & (tag[idx] == lookup tag).
  - pred_taken = pred_hit & cnt[idx][CNT_W-1].
  - pred_target = pred_taken ? target[idx] : pc_lookup + 4, with 32-bit wrap.
- Update applies only when upd_valid = 1.
  - Hit, taken: cnt increments and saturates at 2^CNT_W−1; target ← upd_target.
  - Hit, not taken: cnt decrements and saturates at 0; target unchanged.
  - Miss, taken: allocate, overwriting any aliasing entry. valid ← 1, tag ← upd tag, cnt ← 2^(CNT_W−1) (weakly taken), target ← upd_target.
  - Miss, not taken: no change.
- Counters: stat_branches += 1 on every upd_valid. stat_mispredicts += 1 when upd_mispredict is also set. Both wrap modulo 2^32.
- Reset (reset_0 = 0, asynchronous, takes effect immediately, including mid-update):
  - all valid ← 0
  - all cnt ← 2^(CNT_W−1)−1 (weakly not taken)
  - all targets ← 0
  - both stats ← 0
  - resulting outputs: pred_hit = 0, pred_taken = 0, pred_target = pc_lookup+4, stats = 0

## Timing
- Lookup latency: 0 cycles (combinational).
- Update latency: written at the rising edge that samples upd_valid; visible to lookup from the next cycle.
- Lookup and update to the same index in the same cycle: lookup returns pre-update contents. There is no bypass.
- Only one update per cycle. The ID stage must not assert upd_valid while `stall` is high.
- Reset release is synchronous to `clock`. The first update is accepted at the first rising edge after reset_0 rises.

## Structure
- Shared defines header `pipeline_defs.vh` holds:
  - default parameter values
  - the PC increment constant (4)
- Sub-module `sat_counter`, parameterised by CNT_W.
  - Inputs: current value, inc, dec.
  - Output: next value, saturated at both ends.
  - Instantiated once on the update path.
- Storage uses register arrays. No memory macros, because async reset must clear valid bits.

## Test plan
All scenarios use ENTRIES=16, TAG_W=8, CNT_W=2. For pc 0x40: idx 0, tag 0x01.
1. Reset, then lookup 0x40 → hit 0, taken 0, target 0x44; stats 0/0.
2. Update 0x40 taken, target 0x100 → next cycle lookup 0x40 gives hit 1, taken 1, target 0x100, cnt 2.
   - Two more taken updates → cnt saturates at 3.
   - Not-taken updates → cnt 2, still taken → cnt 1, not taken, target 0x44, hit 1 → cnt 0, then stays 0.
3. Aliasing:
   - With 0x40 allocated, lookup 0x80 (idx 0, tag 0x02) → hit 0.
   - Update 0x80 taken, target 0x200 → lookup 0x80 gives hit 1, target 0x200; lookup 0x40 gives hit 0.
   - Update 0x80 not taken on a fresh table → no allocation.
4. Same-cycle hazard: lookup 0x40 while updating 0x40 (cnt 1→2) → that cycle taken 0; next cycle taken 1.
5. Statistics: 10 updates, 3 with upd_mispredict → stat_branches 10, stat_mispredicts 3.
   - upd_mispredict high with upd_valid low → no count.
6. Reset mid-run: assert reset_0 between clock edges while upd_valid = 1 → outputs clear immediately; no entry is written at the next edge.
